alt_vipvfr131_common_timing_detector: RTL and testbench
=======================================================

// Module: alt_vipvfr131_common_timing_detector
// PURPOSE
//  Receive-side counterpart of the frame counter. It measures h_total/v_total of an incoming sync stream,
//  tracks the current h/v position and asserts locked once timing is stable.
//  Sits in the clocked-video input path. It feeds totals to the frame counter and to the resolution-change logic.
// PARAMETERS
//  H_SYNC_ACTIVE_HIGH  1  hsync polarity; leading edge = transition into the active level
//  V_SYNC_ACTIVE_HIGH  1  vsync polarity; same leading-edge rule
//  TOTALS_MINUS_ONE    0  1: h_total/v_total report total-1 (frame counter convention); 0: true totals
//  LOCK_FRAMES         2  consecutive identical frames required to assert locked (1..15)
// PORTS
//  clk          in   1   clock
//  rst_n        in   1   reset, synchronous, active-low
//  sclr         in   1   synchronous clear; same effect as reset
//  enable       in   1   sample-cycle qualifier; all sync sampling and counting occur only when high
//  hsync        in   1   incoming horizontal sync
//  vsync        in   1   incoming vertical sync
//  h_count      out  14  current sample position in line; 0 on hsync leading-edge cycle
//  v_count      out  13  current line in frame; 0 on first line after vsync
//  h_total      out  14  measured samples per line (see TOTALS_MINUS_ONE)
//  v_total      out  13  measured lines per frame
//  locked       out  1   timing stable for LOCK_FRAMES frames
//  changed      out  1   one-cycle pulse when locked falls or reported totals change
//  overflow     out  1   sticky; h_count or v_count saturated since last clear
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge) or sclr=1: every output and all state go to 0. State goes to IDLE.
//  Edge detect: hs_lead = enable & hs_act & ~hs_prev. hs_prev updates only on enable cycles. vsync is handled the same way.
//  Line counting: on hs_lead: h_meas <= h_count+1, h_count <= 0. Else on enable: h_count+1, saturating at 14'h3FFF.
//  Frame counting: vs_lead sets v_pend. At the next hs_lead, or the same cycle: v_meas <= v_count+1, v_count <= 0, v_pend <= 0.
//    On any other hs_lead: v_count+1, saturating at 13'h1FFF.
//  Saturation of either counter sets overflow and forces state to IDLE.
//  Line mismatch: h_meas differs from the previous line's value within the same frame -> frame_bad.
//  FSM states, evaluated only on hs_lead cycles:
//    IDLE     wait for the first frame start -> MEASURE.
//    MEASURE  at the next frame start latch ref_h, ref_v and set match_cnt=1.
//             If LOCK_FRAMES=1 and !frame_bad -> LOCKED; else -> CHECK.
//    CHECK    at a frame start: if match (h,v equal ref, !frame_bad) then match_cnt+1, and -> LOCKED when it reaches LOCK_FRAMES.
//             On mismatch: reload ref, match_cnt=1, stay in CHECK.
//    LOCKED   at a frame start or on line mismatch: a mismatch sets locked=0, pulses changed, reloads ref and -> CHECK.
//  Outputs are registered. locked, h_total and v_total update on the clk edge after the frame-start hs_lead.
//    h_total/v_total hold ref values and change only at lock entry.
//    changed pulses at lock entry if the totals differ from their previous values, and at lock loss.
//  Simultaneous vs_lead and hs_lead: treated as the frame start on that cycle.
//  enable=0: all state holds, including hs_prev and vs_prev.
//  Reset or sclr mid-frame discards partial measurements. The first full frame after IDLE is never trusted.
// STRUCTURE
//  Shared constants in the common package: H_CNT_W=14, V_CNT_W=13, H_MAX, V_MAX, FSM state encodings.
//  One sub-module: alt_vipvfr131_common_sync_edge (polarity normalise + enable-qualified leading-edge pulse), instantiated for hsync and vsync.
//  Counters, compare logic and the FSM live in the top module.
// TESTING
//  800x525 frames, syncs active-high, enable=1, LOCK_FRAMES=2 -> locked rises after the 3rd vsync.
//    Expect h_total=800, v_total=525 and one changed pulse.
//  Same timing with TOTALS_MINUS_ONE=1 -> h_total=799, v_total=524; h_count wraps 799->0, v_count wraps 524->0.
//  Locked at 800x525, then one line of 801 samples -> locked falls next cycle, changed pulses.
//    Relock after 2 clean frames with totals 800/525.
//  enable toggling 1/0 every cycle on a 1650x750 stream -> identical results to enable=1; counts advance only on enable.
//  hsync held inactive for 16384 enabled cycles -> overflow=1, state IDLE, locked=0; sclr clears overflow.
//  Assert rst_n=0 for one cycle mid-frame while locked -> all outputs 0 next cycle; relocks after LOCK_FRAMES+1 frame starts.

Source files
------------

// File: rtl/alt_vipvfr131_common_timing_detector_pkg.sv
// Shared widths, saturation limits and FSM encoding for the timing detector.
package alt_vipvfr131_common_timing_detector_pkg;

  localparam int unsigned H_CNT_W = 14;
  localparam int unsigned V_CNT_W = 13;
  localparam int unsigned MATCH_W = 4;

  localparam logic [H_CNT_W-1:0] H_MAX = {H_CNT_W{1'b1}};
  localparam logic [V_CNT_W-1:0] V_MAX = {V_CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_CHECK   = 2'd2,
    ST_LOCKED  = 2'd3
  } td_state_e;

endpackage

// File: rtl/alt_vipvfr131_common_sync_edge.sv
// Normalises sync polarity and emits an enable-qualified leading-edge pulse.
module alt_vipvfr131_common_sync_edge #(
  parameter bit ACTIVE_HIGH = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_sclr,
  input  logic i_enable,
  input  logic i_sync,
  output logic o_lead_c
);

  logic w_act;
  logic r_prev;

  assign w_act    = ACTIVE_HIGH ? i_sync : ~i_sync;
  assign o_lead_c = i_enable & w_act & ~r_prev;

  // Previous level only advances on sample cycles so gaps never create edges.
  always_ff @(posedge clk) begin
    if (!rst_n || i_sclr) begin
      r_prev <= 1'b0;
    end else if (i_enable) begin
      r_prev <= w_act;
    end
  end

endmodule

// File: rtl/alt_vipvfr131_common_timing_detector.sv
// Measures line/frame totals of an incoming sync stream, tracks position and reports lock.
module alt_vipvfr131_common_timing_detector
  import alt_vipvfr131_common_timing_detector_pkg::*;
#(
  parameter bit          H_SYNC_ACTIVE_HIGH = 1'b1,
  parameter bit          V_SYNC_ACTIVE_HIGH = 1'b1,
  parameter bit          TOTALS_MINUS_ONE   = 1'b0,
  parameter int unsigned LOCK_FRAMES        = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sclr,
  input  logic        enable,
  input  logic        hsync,
  input  logic        vsync,
  output logic [13:0] h_count,
  output logic [12:0] v_count,
  output logic [13:0] h_total,
  output logic [12:0] v_total,
  output logic        locked,
  output logic        changed,
  output logic        overflow
);

  logic               w_hs_lead, w_vs_lead, w_fs;
  logic               w_h_sat, w_v_sat, w_sat;
  logic               w_line_mis, w_bad, w_match;
  logic [H_CNT_W-1:0] w_h_len, w_h_rpt;
  logic [V_CNT_W-1:0] w_v_len, w_v_rpt;
  logic [MATCH_W-1:0] w_cnt_inc;

  logic [H_CNT_W-1:0] r_h_count, r_h_meas, r_ref_h, r_h_total;
  logic [V_CNT_W-1:0] r_v_count, r_ref_v, r_v_total;
  logic [MATCH_W-1:0] r_match_cnt;
  logic               r_h_valid, r_v_pend, r_frame_bad;
  logic               r_locked, r_changed, r_overflow;
  td_state_e          r_state;

  td_state_e          w_state_nxt;
  logic [H_CNT_W-1:0] w_ref_h_nxt, w_h_total_nxt;
  logic [V_CNT_W-1:0] w_ref_v_nxt, w_v_total_nxt;
  logic [MATCH_W-1:0] w_match_nxt;
  logic               w_locked_nxt, w_changed_nxt, w_entry, w_reload;

  alt_vipvfr131_common_sync_edge #(.ACTIVE_HIGH(H_SYNC_ACTIVE_HIGH)) u_hs_edge (
    .clk(clk), .rst_n(rst_n), .i_sclr(sclr), .i_enable(enable), .i_sync(hsync), .o_lead_c(w_hs_lead)
  );

  alt_vipvfr131_common_sync_edge #(.ACTIVE_HIGH(V_SYNC_ACTIVE_HIGH)) u_vs_edge (
    .clk(clk), .rst_n(rst_n), .i_sclr(sclr), .i_enable(enable), .i_sync(vsync), .o_lead_c(w_vs_lead)
  );

  // A frame starts on the line edge that follows (or coincides with) a vsync edge.
  assign w_fs       = w_hs_lead & (r_v_pend | w_vs_lead);
  assign w_h_len    = r_h_count + H_CNT_W'(1);
  assign w_v_len    = r_v_count + V_CNT_W'(1);
  assign w_h_sat    = enable & ~w_hs_lead & (r_h_count == H_MAX);
  assign w_v_sat    = w_hs_lead & ~w_fs & (r_v_count == V_MAX);
  assign w_sat      = w_h_sat | w_v_sat;
  assign w_line_mis = w_hs_lead & r_h_valid & (w_h_len != r_h_meas);
  assign w_bad      = r_frame_bad | w_line_mis;
  assign w_match    = (w_h_len == r_ref_h) & (w_v_len == r_ref_v) & ~w_bad;
  assign w_cnt_inc  = r_match_cnt + MATCH_W'(1);
  assign w_h_rpt    = TOTALS_MINUS_ONE ? (w_h_len - H_CNT_W'(1)) : w_h_len;
  assign w_v_rpt    = TOTALS_MINUS_ONE ? (w_v_len - V_CNT_W'(1)) : w_v_len;

  // Position counters and per-frame line-consistency tracking.
  always_ff @(posedge clk) begin
    if (!rst_n || sclr) begin
      r_h_count   <= '0;
      r_v_count   <= '0;
      r_h_meas    <= '0;
      r_h_valid   <= 1'b0;
      r_v_pend    <= 1'b0;
      r_frame_bad <= 1'b0;
      r_overflow  <= 1'b0;
    end else if (enable) begin
      if (w_hs_lead) begin
        r_h_count <= '0;
        r_h_meas  <= w_h_len;
        if (w_fs) begin
          r_v_count   <= '0;
          r_v_pend    <= 1'b0;
          r_frame_bad <= 1'b0;
          r_h_valid   <= 1'b0;
        end else begin
          if (!w_v_sat) r_v_count <= w_v_len;
          r_frame_bad <= w_bad;
          r_h_valid   <= 1'b1;
        end
      end else begin
        if (!w_h_sat) r_h_count <= w_h_len;
        if (w_vs_lead) r_v_pend <= 1'b1;
      end
      if (w_sat) r_overflow <= 1'b1;
    end
  end

  // FSM state and lock-related registers.
  always_ff @(posedge clk) begin
    if (!rst_n || sclr) begin
      r_state     <= ST_IDLE;
      r_ref_h     <= '0;
      r_ref_v     <= '0;
      r_match_cnt <= '0;
      r_locked    <= 1'b0;
      r_changed   <= 1'b0;
      r_h_total   <= '0;
      r_v_total   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_ref_h     <= w_ref_h_nxt;
      r_ref_v     <= w_ref_v_nxt;
      r_match_cnt <= w_match_nxt;
      r_locked    <= w_locked_nxt;
      r_changed   <= w_changed_nxt;
      r_h_total   <= w_h_total_nxt;
      r_v_total   <= w_v_total_nxt;
    end
  end

  // Next-state: decisions happen only on line edges; saturation overrides everything.
  always_comb begin
    w_state_nxt   = r_state;
    w_ref_h_nxt   = r_ref_h;
    w_ref_v_nxt   = r_ref_v;
    w_match_nxt   = r_match_cnt;
    w_locked_nxt  = r_locked;
    w_h_total_nxt = r_h_total;
    w_v_total_nxt = r_v_total;
    w_changed_nxt = 1'b0;
    w_entry       = 1'b0;
    w_reload      = 1'b0;
    if (w_sat) begin
      w_state_nxt  = ST_IDLE;
      w_locked_nxt = 1'b0;
    end else if (w_hs_lead) begin
      case (r_state)
        ST_IDLE: begin
          if (w_fs) w_state_nxt = ST_MEASURE;
        end
        ST_MEASURE: begin
          if (w_fs) begin
            w_reload = 1'b1;
            w_entry  = (LOCK_FRAMES == 1) && !w_bad;
          end
        end
        ST_CHECK: begin
          if (w_fs) begin
            if (w_match) begin
              w_match_nxt = w_cnt_inc;
              w_entry     = (w_cnt_inc >= MATCH_W'(LOCK_FRAMES));
            end else begin
              w_reload = 1'b1;
            end
          end
        end
        ST_LOCKED: begin
          if (w_fs ? !w_match : w_line_mis) begin
            w_locked_nxt = 1'b0;
            w_reload     = 1'b1;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
    if (w_reload) begin
      w_ref_h_nxt = w_h_len;
      w_ref_v_nxt = w_v_len;
      w_match_nxt = MATCH_W'(1);
      w_state_nxt = ST_CHECK;
    end
    if (w_entry) begin
      w_state_nxt   = ST_LOCKED;
      w_locked_nxt  = 1'b1;
      w_h_total_nxt = w_h_rpt;
      w_v_total_nxt = w_v_rpt;
    end
    w_changed_nxt = (r_locked & ~w_locked_nxt) |
                    (w_entry & ((w_h_rpt != r_h_total) | (w_v_rpt != r_v_total)));
  end

  assign h_count  = r_h_count;
  assign v_count  = r_v_count;
  assign h_total  = r_h_total;
  assign v_total  = r_v_total;
  assign locked   = r_locked;
  assign changed  = r_changed;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_alt_vipvfr131_common_timing_detector.sv
// Randomised sync streams checked cycle by cycle against a line/frame-level timing model.
module tb_alt_vipvfr131_common_timing_detector;

  localparam int LOCK = 2;

  logic clk = 1'b0;
  logic rst_n, sclr, enable, hsync, vsync;
  logic [13:0] hc0, hc1, ht0, ht1;
  logic [12:0] vc0, vc1, vt0, vt1;
  logic lk0, lk1, ch0, ch1, ov0, ov1;

  int n_vec = 0;
  int n_err = 0;
  int n_chg = 0;
  bit gap   = 1'b0;

  // Reference model state: stream-level quantities, not RTL registers.
  bit m_ph, m_pv, m_pend, m_locked, m_chg, m_ovf, m_totset;
  int m_pos, m_line, m_phase, m_streak, m_ref_h, m_ref_v, m_toth, m_totv;
  int q[$];

  always #5 clk = ~clk;

  alt_vipvfr131_common_timing_detector #(.TOTALS_MINUS_ONE(1'b0), .LOCK_FRAMES(LOCK)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .sclr(sclr), .enable(enable), .hsync(hsync), .vsync(vsync),
    .h_count(hc0), .v_count(vc0), .h_total(ht0), .v_total(vt0),
    .locked(lk0), .changed(ch0), .overflow(ov0)
  );

  alt_vipvfr131_common_timing_detector #(.TOTALS_MINUS_ONE(1'b1), .LOCK_FRAMES(LOCK)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .sclr(sclr), .enable(enable), .hsync(hsync), .vsync(vsync),
    .h_count(hc1), .v_count(vc1), .h_total(ht1), .v_total(vt1),
    .locked(lk1), .changed(ch1), .overflow(ov1)
  );

  function automatic logic [63:0] pk(input logic [13:0] hc, input logic [12:0] vc,
                                     input logic [13:0] ht, input logic [12:0] vt,
                                     input logic l, input logic c, input logic o);
    return {7'd0, hc, vc, ht, vt, l, c, o};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_ph = 0; m_pv = 0; m_pend = 0; m_locked = 0; m_chg = 0; m_ovf = 0; m_totset = 0;
    m_pos = 0; m_line = 0; m_phase = 0; m_streak = 0; m_ref_h = 0; m_ref_v = 0;
    m_toth = 0; m_totv = 0;
    q.delete();
  endtask

  task automatic m_lose();
    if (m_locked) begin
      m_locked = 0;
      m_chg    = 1;
    end
  endtask

  task automatic m_lock(input int hl, input int vl);
    m_locked = 1;
    if (hl != m_toth || vl != m_totv) m_chg = 1;
    m_toth = hl; m_totv = vl; m_totset = 1;
  endtask

  // A frame has ended with the given totals; apply the lock rules.
  task automatic m_frame_end(input int hl, input int vl, input bit bad);
    bit match;
    match = (hl == m_ref_h) && (vl == m_ref_v) && !bad;
    if (m_phase == 0) begin
      m_phase = 1;
    end else if (m_phase == 1) begin
      m_ref_h = hl; m_ref_v = vl; m_streak = 1; m_phase = 2;
      if (LOCK == 1 && !bad) m_lock(hl, vl);
    end else if (m_locked) begin
      if (!match) begin
        m_lose();
        m_ref_h = hl; m_ref_v = vl; m_streak = 1;
      end
    end else if (match) begin
      m_streak++;
      if (m_streak >= LOCK) m_lock(hl, vl);
    end else begin
      m_ref_h = hl; m_ref_v = vl; m_streak = 1;
    end
  endtask

  task automatic m_overflow();
    m_ovf = 1;
    m_phase = 0;
    m_lose();
  endtask

  task automatic m_step(input bit r, input bit s, input bit e, input bit hs, input bit vs);
    bit hl, vl, fs, mis, bad;
    int len, vlen;
    if (!r || s) begin
      m_reset();
      return;
    end
    m_chg = 0;
    if (!e) return;
    hl = hs && !m_ph;
    vl = vs && !m_pv;
    m_ph = hs;
    m_pv = vs;
    if (hl) begin
      len = (m_pos + 1) % 16384;
      fs  = m_pend || vl;
      mis = (q.size() > 0) && (q[q.size()-1] != len);
      q.push_back(len);
      m_pos = 0;
      if (fs) begin
        bad = 0;
        foreach (q[i]) if (q[i] != q[0]) bad = 1;
        vlen = (m_line + 1) % 8192;
        m_line = 0; m_pend = 0;
        q.delete();
        m_frame_end(len, vlen, bad);
      end else if (m_line == 8191) begin
        m_overflow();
      end else begin
        m_line++;
        if (m_locked && mis) begin
          m_lose();
          m_ref_h = len; m_ref_v = m_line; m_streak = 1;
        end
      end
    end else begin
      if (m_pos == 16383) m_overflow();
      else m_pos++;
      if (vl) m_pend = 1;
    end
  endtask

  task automatic cyc(input bit hs, input bit vs, input bit en);
    logic [13:0] e1h;
    logic [12:0] e1v;
    hsync = hs; vsync = vs; enable = en;
    @(posedge clk);
    m_step(rst_n, sclr, en, hs, vs);
    #1;
    e1h = m_totset ? 14'(m_toth - 1) : 14'd0;
    e1v = m_totset ? 13'(m_totv - 1) : 13'd0;
    chk("dut0_outputs", pk(hc0, vc0, ht0, vt0, lk0, ch0, ov0),
        pk(14'(m_pos), 13'(m_line), 14'(m_toth), 13'(m_totv), m_locked, m_chg, m_ovf));
    chk("dut1_outputs", pk(hc1, vc1, ht1, vt1, lk1, ch1, ov1),
        pk(14'(m_pos), 13'(m_line), e1h, e1v, m_locked, m_chg, m_ovf));
    if (ch0) n_chg++;
  endtask

  // One enabled sample, optionally preceded by a disabled cycle carrying random syncs.
  task automatic smp(input bit hs, input bit vs);
    if (gap) cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    cyc(hs, vs, 1'b1);
  endtask

  task automatic frame(input int h, input int v, input int voff, input int long_ln);
    for (int ln = 0; ln < v; ln++) begin
      int len;
      len = (ln == long_ln) ? h + 1 : h;
      for (int s = 0; s < len; s++)
        smp(s < 3, (ln == 0) && (s >= voff) && (s < voff + 2));
    end
  endtask

  task automatic chk_lock(input string tag, input int h, input int v);
    chk({tag, "_locked"}, 64'(lk0), 64'd1);
    chk({tag, "_h_total"}, 64'(ht0), 64'(h));
    chk({tag, "_v_total"}, 64'(vt0), 64'(v));
    chk({tag, "_h_total_m1"}, 64'(ht1), 64'(h - 1));
    chk({tag, "_v_total_m1"}, 64'(vt1), 64'(v - 1));
  endtask

  initial begin
    rst_n = 1'b0; sclr = 1'b0; enable = 1'b0; hsync = 1'b0; vsync = 1'b0;
    m_reset();

    // Reset state.
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1);
    chk("reset_dut0", pk(hc0, vc0, ht0, vt0, lk0, ch0, ov0), 64'd0);
    chk("reset_dut1", pk(hc1, vc1, ht1, vt1, lk1, ch1, ov1), 64'd0);
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b1);

    // Clean 20x12 stream: lock on the third frame start with a single changed pulse.
    n_chg = 0;
    frame(20, 12, 0, -1);
    frame(20, 12, 0, -1);
    chk("prelock_A", 64'(lk0), 64'd0);
    frame(20, 12, 0, -1);
    chk_lock("lock_A", 20, 12);
    chk("changed_count_A", 64'(n_chg), 64'd1);

    // One long line drops lock; two clean frames restore it at the same totals.
    n_chg = 0;
    frame(20, 12, 0, 5);
    chk("unlock_B", 64'(lk0), 64'd0);
    frame(20, 12, 0, -1);
    frame(20, 12, 0, -1);
    frame(20, 12, 0, -1);
    chk_lock("relock_B", 20, 12);
    chk("changed_count_B", 64'(n_chg), 64'd1);

    // Random geometries, vsync phases and enable gaps.
    for (int k = 0; k < 3; k++) begin
      int h, v, voff;
      h    = int'($urandom_range(10, 40));
      v    = int'($urandom_range(4, 10));
      voff = int'($urandom_range(0, h - 3));
      gap  = 1'($urandom_range(0, 1));
      for (int f = 0; f < 5; f++) frame(h, v, voff, -1);
      chk_lock("lock_rand", h, v);
    end
    gap = 1'b0;

    // hsync stuck inactive: counter saturates, overflow sticks, lock drops; sclr clears.
    for (int i = 0; i < 16390; i++) cyc(1'b0, 1'b0, 1'b1);
    chk("ovf_set", 64'(ov0), 64'd1);
    chk("ovf_unlocked", 64'(lk0), 64'd0);
    chk("ovf_h_sat", 64'(hc0), 64'h3FFF);
    sclr = 1'b1;
    cyc(1'b0, 1'b0, 1'b1);
    sclr = 1'b0;
    chk("ovf_cleared", 64'(ov0), 64'd0);

    // Mid-frame reset while locked, then relock after LOCK+1 frame starts.
    for (int f = 0; f < 4; f++) frame(24, 8, 0, -1);
    chk_lock("lock_E", 24, 8);
    frame(24, 3, 0, -1);
    rst_n = 1'b0;
    cyc(1'b0, 1'b0, 1'b1);
    rst_n = 1'b1;
    chk("midreset_dut0", pk(hc0, vc0, ht0, vt0, lk0, ch0, ov0), 64'd0);
    chk("midreset_dut1", pk(hc1, vc1, ht1, vt1, lk1, ch1, ov1), 64'd0);
    for (int f = 0; f < 3; f++) frame(24, 8, 0, -1);
    chk_lock("relock_E", 24, 8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
